ex_unit_m: RTL and testbench
============================

# ex_unit_m

Parametrised out-of-order execution unit: takes one issued operation per cycle from the reservation station and broadcasts its result, tagged with the ROB index, to RS, LSB and ROB. It is generalised in data width and tag width, fixes branch-compare semantics, and adds RV32M multiply, with single-cycle latency, and divide/remainder, with an iterative multi-cycle divider. A `flush` input kills in-flight work on misprediction. The multi-cycle divider makes the unit non-blocking-until-busy, so it exports a ready signal to the RS.

## Interface
- `XLEN`, 32, operand/result width; must be a power of two, ≥ 8
- `ROB_W`, 4, ROB tag width
- `OP_W`, 6, opcode width; codes come from the shared package
- `clk` input 1: the single clock.
- `rst` input 1: reset, synchronous and active-high.
- `en` input 1 — global clock enable; when 0, all state holds, including the divider.
- `flush` input 1 — misprediction clear; takes priority over everything except `rst`.
- `iRS_En` input 1 — issue valid.
- `oRS_Ready` output 1 — unit can accept an issue this cycle.
- `iRS_Op` input OP_W; `iRS_Pc`, `iRS_Imm`, `iRS_Vs1`, `iRS_Vs2` input XLEN; `iRS_Qd` input ROB_W
- `oCDB_En` output 1 — result valid, for one cycle.
- `oCDB_Qd` output ROB_W; `oCDB_Vd` output XLEN: result value; `oCDB_Jt` output XLEN: jump/branch target.

## Operation
- Issue is accepted when `en && iRS_En && oRS_Ready && !flush`. Issue while not ready is a protocol error; it is ignored and must be asserted against in simulation.
- ALU ops: LUI, AUIPC, JAL/JALR (Vd=pc+4), ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI, ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND.
  - All shift amounts are the low log2(XLEN) bits of imm or vs2.
  - SRA/SRAI are arithmetic (sign-filling).
- Branches, with Jt = taken ? pc+imm : pc+4:
  - BEQ, BNE, BLT (signed), BGE (signed ≥), BLTU, BGEU (unsigned ≥).
  - Branch Vd = 0.
- JALR: Jt = (vs1+imm) with bit 0 cleared. JAL: Jt = pc+imm.
- Jt = 0 for all non-control ops.
- MUL, MULH, MULHSU, MULHU: computed from a 2·XLEN product, returning the low or high half as per RV32M. Latency is 1, the same as the ALU.
- DIV, DIVU, REM, REMU are handled by the sub-module. States are IDLE → CALC → DONE → IDLE.
  - Restoring radix-2 on magnitudes, with the sign fixed up in DONE.
  - Divide by zero: quotient = all ones, remainder = dividend.
  - Signed overflow (−2^(XLEN−1) / −1): quotient = dividend, remainder = 0.
  - Special cases are detected at issue and complete with ALU latency, bypassing CALC.
- `oRS_Ready` = 0 while the divider is in CALC or DONE; otherwise 1.
- Every arithmetic result is truncated to XLEN bits.

## Timing
- Reset: `oCDB_En`=0, `oCDB_Qd`=0, `oCDB_Vd`=0, `oCDB_Jt`=0, divider IDLE, `oRS_Ready`=1.
- ALU, MUL and branch ops:
  - Issue accepted at edge N → outputs valid in the cycle after edge N.
  - `oCDB_En` is high for exactly one cycle.
  - Back-to-back issue gives one result per cycle.
- Divide:
  - Issue accepted at edge N → CALC during edges N+1 … N+XLEN → DONE at edge N+XLEN.
  - At edge N+XLEN+1 the result is registered, `oCDB_En`=1 and the state returns to IDLE.
  - `oRS_Ready` is low from after edge N until edge N+XLEN+1. It is high in the same cycle the divide result is broadcast.
  - No new issue is accepted during this window, so the broadcast has no conflict.
- Idle cycles (no accepted issue, no divide completion): `oCDB_En`=0, and Qd/Vd/Jt are driven to 0.
- `flush` at edge F:
  - Divider → IDLE and `oCDB_En`=0 after edge F, even if a result would have been produced at F.
  - Any issue presented at edge F is dropped.
  - `oRS_Ready`=1 after edge F.
- `rst` asserted mid-divide returns everything to reset values at that edge.
- `en` low: no state change. `oCDB_En` holds its value, so consumers must gate with `en`, as they already do.

## Structure
- A shared package (header) holds:
  - All opcode constants (existing 5-bit codes zero-extended to OP_W; MUL..REMU = 6'h20..6'h27).
  - `XLEN`/`ROB_W` default macros.
  - Divider state encoding.
- Sub-module `ex_div_unit`: the iterative divider. It has XLEN/ROB_W parameters, a start/flush input, a done pulse, and the tag and result held internally.
- The top level contains the combinational ALU/MUL/branch logic and the output register.

## Test plan
- ADDI vs1=5, imm=−3, Qd=7 → next cycle En=1, Qd=7, Vd=2, Jt=0; the following cycle En=0.
- BGE vs1=vs2=9, pc=0x100, imm=0x20 → Jt=0x120. BGEU vs1=1, vs2=0xFFFFFFFF → Jt=0x104.
- MULH vs1=0x80000000, vs2=2 → Vd=0xFFFFFFFF. MULHU on the same operands → Vd=1.
- DIV −7/2, Qd=3, issued at edge N:
  - `oRS_Ready` low for 33 cycles.
  - En=1 at N+33 with Vd=−3.
  - REM on the same operands → Vd=−1.
- DIVU x/0 → Vd=0xFFFFFFFF with ALU latency. DIV 0x80000000/−1 → Vd=0x80000000.
- Flush at cycle 10 of a divide → no result broadcast; `oRS_Ready`=1 next cycle; an ADD issued immediately afterwards returns normally.

Source files
------------

// File: rtl/ex_unit_m_pkg.sv
// Shared definitions for the execution unit: opcode map, default widths and
// the divider state encoding. Opcodes are 6-bit; consumers with a wider
// opcode bus compare against these zero-extended.

`ifndef EX_UNIT_XLEN
`define EX_UNIT_XLEN 32
`endif

`ifndef EX_UNIT_ROB_W
`define EX_UNIT_ROB_W 4
`endif

package ex_unit_m_pkg;

  localparam int OP_W_DEF = 6;

  // Base integer opcodes (original 5-bit codes, zero-extended)
  localparam logic [5:0] OP_LUI   = 6'h00;
  localparam logic [5:0] OP_AUIPC = 6'h01;
  localparam logic [5:0] OP_JAL   = 6'h02;
  localparam logic [5:0] OP_JALR  = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_BLT   = 6'h06;
  localparam logic [5:0] OP_BGE   = 6'h07;
  localparam logic [5:0] OP_BLTU  = 6'h08;
  localparam logic [5:0] OP_BGEU  = 6'h09;
  localparam logic [5:0] OP_ADDI  = 6'h0A;
  localparam logic [5:0] OP_SLTI  = 6'h0B;
  localparam logic [5:0] OP_SLTIU = 6'h0C;
  localparam logic [5:0] OP_XORI  = 6'h0D;
  localparam logic [5:0] OP_ORI   = 6'h0E;
  localparam logic [5:0] OP_ANDI  = 6'h0F;
  localparam logic [5:0] OP_SLLI  = 6'h10;
  localparam logic [5:0] OP_SRLI  = 6'h11;
  localparam logic [5:0] OP_SRAI  = 6'h12;
  localparam logic [5:0] OP_ADD   = 6'h13;
  localparam logic [5:0] OP_SUB   = 6'h14;
  localparam logic [5:0] OP_SLL   = 6'h15;
  localparam logic [5:0] OP_SLT   = 6'h16;
  localparam logic [5:0] OP_SLTU  = 6'h17;
  localparam logic [5:0] OP_XOR   = 6'h18;
  localparam logic [5:0] OP_SRL   = 6'h19;
  localparam logic [5:0] OP_SRA   = 6'h1A;
  localparam logic [5:0] OP_OR    = 6'h1B;
  localparam logic [5:0] OP_AND   = 6'h1C;

  // RV32M extension
  localparam logic [5:0] OP_MUL    = 6'h20;
  localparam logic [5:0] OP_MULH   = 6'h21;
  localparam logic [5:0] OP_MULHSU = 6'h22;
  localparam logic [5:0] OP_MULHU  = 6'h23;
  localparam logic [5:0] OP_DIV    = 6'h24;
  localparam logic [5:0] OP_DIVU   = 6'h25;
  localparam logic [5:0] OP_REM    = 6'h26;
  localparam logic [5:0] OP_REMU   = 6'h27;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_CALC = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/ex_div_unit.sv
// Iterative restoring radix-2 divider. Works on operand magnitudes for
// XLEN cycles in CALC, then presents the sign-corrected quotient or
// remainder with a one-cycle done pulse in DONE. Special cases (divide by
// zero, signed overflow) never reach this block.

module ex_div_unit
  import ex_unit_m_pkg::*;
#(
  parameter int XLEN  = `EX_UNIT_XLEN,
  parameter int ROB_W = `EX_UNIT_ROB_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             flush,
  input  logic             start,
  input  logic             is_signed,
  input  logic             is_rem,
  input  logic [XLEN-1:0]  dividend,
  input  logic [XLEN-1:0]  divisor,
  input  logic [ROB_W-1:0] tag_in,
  output logic             idle,
  output logic             done,
  output logic [ROB_W-1:0] tag,
  output logic [XLEN-1:0]  result
);

  localparam int CNT_W = $clog2(XLEN);

  div_state_e       state;
  logic [CNT_W-1:0] count;
  logic [XLEN-1:0]  rem_q;
  logic [XLEN-1:0]  quo_q;
  logic [XLEN-1:0]  dsr_q;
  logic             neg_quo;
  logic             neg_rem;
  logic             sel_rem;
  logic [ROB_W-1:0] tag_q;

  logic [XLEN:0]    shifted;
  logic [XLEN:0]    diff;
  logic [XLEN-1:0]  next_rem;
  logic [XLEN-1:0]  next_quo;
  logic [XLEN-1:0]  dividend_mag;
  logic [XLEN-1:0]  divisor_mag;

  assign dividend_mag = (is_signed && dividend[XLEN-1]) ? (~dividend + 1'b1) : dividend;
  assign divisor_mag  = (is_signed && divisor[XLEN-1])  ? (~divisor + 1'b1)  : divisor;

  // One restoring step: bring in the next dividend bit and try to subtract.
  always_comb begin
    shifted  = {rem_q, quo_q[XLEN-1]};
    diff     = shifted - {1'b0, dsr_q};
    next_rem = shifted[XLEN-1:0];
    next_quo = {quo_q[XLEN-2:0], 1'b0};
    if (!diff[XLEN]) begin
      next_rem = diff[XLEN-1:0];
      next_quo = {quo_q[XLEN-2:0], 1'b1};
    end
  end

  // Divider FSM: latch magnitudes and signs on start, iterate, then report.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= DIV_IDLE;
      count   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dsr_q   <= '0;
      neg_quo <= 1'b0;
      neg_rem <= 1'b0;
      sel_rem <= 1'b0;
      tag_q   <= '0;
    end else if (en) begin
      if (flush) begin
        state <= DIV_IDLE;
      end else begin
        case (state)
          DIV_IDLE: begin
            if (start) begin
              state   <= DIV_CALC;
              count   <= '0;
              rem_q   <= '0;
              quo_q   <= dividend_mag;
              dsr_q   <= divisor_mag;
              neg_quo <= is_signed & (dividend[XLEN-1] ^ divisor[XLEN-1]);
              neg_rem <= is_signed & dividend[XLEN-1];
              sel_rem <= is_rem;
              tag_q   <= tag_in;
            end
          end
          DIV_CALC: begin
            rem_q <= next_rem;
            quo_q <= next_quo;
            count <= count + 1'b1;
            if (count == CNT_W'(XLEN - 1)) begin
              state <= DIV_DONE;
            end
          end
          DIV_DONE: state <= DIV_IDLE;
          default:  state <= DIV_IDLE;
        endcase
      end
    end
  end

  assign idle   = (state == DIV_IDLE);
  assign done   = (state == DIV_DONE);
  assign tag    = tag_q;
  assign result = sel_rem ? (neg_rem ? (~rem_q + 1'b1) : rem_q)
                          : (neg_quo ? (~quo_q + 1'b1) : quo_q);

endmodule

// File: rtl/ex_unit_m.sv
// Execution unit: single-cycle ALU, branch and multiply paths plus an
// iterative divider. Results are registered and broadcast on the CDB with
// the ROB tag of the issuing operation.

module ex_unit_m
  import ex_unit_m_pkg::*;
#(
  parameter int XLEN  = `EX_UNIT_XLEN,
  parameter int ROB_W = `EX_UNIT_ROB_W,
  parameter int OP_W  = OP_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             flush,
  input  logic             iRS_En,
  output logic             oRS_Ready,
  input  logic [OP_W-1:0]  iRS_Op,
  input  logic [XLEN-1:0]  iRS_Pc,
  input  logic [XLEN-1:0]  iRS_Imm,
  input  logic [XLEN-1:0]  iRS_Vs1,
  input  logic [XLEN-1:0]  iRS_Vs2,
  input  logic [ROB_W-1:0] iRS_Qd,
  output logic             oCDB_En,
  output logic [ROB_W-1:0] oCDB_Qd,
  output logic [XLEN-1:0]  oCDB_Vd,
  output logic [XLEN-1:0]  oCDB_Jt
);

  localparam int SH_W = $clog2(XLEN);

  logic                    accept;
  logic                    div_start;
  logic                    div_idle;
  logic                    div_done;
  logic [ROB_W-1:0]        div_tag;
  logic [XLEN-1:0]         div_result;

  logic                    is_div;
  logic                    div_signed;
  logic                    div_rem;
  logic                    div_zero;
  logic                    div_ovf;
  logic                    div_special;
  logic [XLEN-1:0]         div_special_vd;

  logic                    mul_a_sgn;
  logic                    mul_b_sgn;
  logic signed [XLEN:0]    mul_a;
  logic signed [XLEN:0]    mul_b;
  logic signed [2*XLEN+1:0] mul_p;

  logic [XLEN-1:0]         pc_plus4;
  logic [XLEN-1:0]         pc_plus_imm;
  logic [XLEN-1:0]         vs1_plus_imm;
  logic [SH_W-1:0]         sh_imm;
  logic [SH_W-1:0]         sh_reg;
  logic                    eq;
  logic                    lt_s;
  logic                    lt_u;
  logic                    lti_s;
  logic                    lti_u;
  logic [XLEN-1:0]         vd_n;
  logic [XLEN-1:0]         jt_n;

  assign oRS_Ready = div_idle;
  assign accept    = en && iRS_En && oRS_Ready && !flush;

  assign pc_plus4     = iRS_Pc + XLEN'(4);
  assign pc_plus_imm  = iRS_Pc + iRS_Imm;
  assign vs1_plus_imm = iRS_Vs1 + iRS_Imm;
  assign sh_imm       = iRS_Imm[SH_W-1:0];
  assign sh_reg       = iRS_Vs2[SH_W-1:0];
  assign eq           = (iRS_Vs1 == iRS_Vs2);
  assign lt_s         = ($signed(iRS_Vs1) < $signed(iRS_Vs2));
  assign lt_u         = (iRS_Vs1 < iRS_Vs2);
  assign lti_s        = ($signed(iRS_Vs1) < $signed(iRS_Imm));
  assign lti_u        = (iRS_Vs1 < iRS_Imm);

  // Decode the M-extension variants: operand signedness and divide flavour.
  always_comb begin
    mul_a_sgn  = 1'b0;
    mul_b_sgn  = 1'b0;
    is_div     = 1'b0;
    div_signed = 1'b0;
    div_rem    = 1'b0;
    case (iRS_Op)
      OP_W'(OP_MULH):   begin mul_a_sgn = 1'b1; mul_b_sgn = 1'b1; end
      OP_W'(OP_MULHSU): mul_a_sgn = 1'b1;
      OP_W'(OP_DIV):    begin is_div = 1'b1; div_signed = 1'b1; end
      OP_W'(OP_DIVU):   is_div = 1'b1;
      OP_W'(OP_REM):    begin is_div = 1'b1; div_signed = 1'b1; div_rem = 1'b1; end
      OP_W'(OP_REMU):   begin is_div = 1'b1; div_rem = 1'b1; end
      default:          ;
    endcase
  end

  // One XLEN+1 signed multiplier covers all four multiply flavours.
  assign mul_a = {mul_a_sgn & iRS_Vs1[XLEN-1], iRS_Vs1};
  assign mul_b = {mul_b_sgn & iRS_Vs2[XLEN-1], iRS_Vs2};
  assign mul_p = mul_a * mul_b;

  assign div_zero       = (iRS_Vs2 == '0);
  assign div_ovf        = div_signed && (iRS_Vs1 == {1'b1, {(XLEN-1){1'b0}}}) && (&iRS_Vs2);
  assign div_special    = is_div && (div_zero || div_ovf);
  assign div_special_vd = div_rem ? (div_zero ? iRS_Vs1 : '0)
                                  : (div_zero ? '1 : iRS_Vs1);
  assign div_start      = accept && is_div && !div_special;

  // Single-cycle result and jump target for everything except iterative divides.
  always_comb begin
    vd_n = '0;
    jt_n = '0;
    case (iRS_Op)
      OP_W'(OP_LUI):    vd_n = iRS_Imm;
      OP_W'(OP_AUIPC):  vd_n = pc_plus_imm;
      OP_W'(OP_JAL):    begin vd_n = pc_plus4; jt_n = pc_plus_imm; end
      OP_W'(OP_JALR):   begin vd_n = pc_plus4; jt_n = {vs1_plus_imm[XLEN-1:1], 1'b0}; end
      OP_W'(OP_BEQ):    jt_n = eq     ? pc_plus_imm : pc_plus4;
      OP_W'(OP_BNE):    jt_n = !eq    ? pc_plus_imm : pc_plus4;
      OP_W'(OP_BLT):    jt_n = lt_s   ? pc_plus_imm : pc_plus4;
      OP_W'(OP_BGE):    jt_n = !lt_s  ? pc_plus_imm : pc_plus4;
      OP_W'(OP_BLTU):   jt_n = lt_u   ? pc_plus_imm : pc_plus4;
      OP_W'(OP_BGEU):   jt_n = !lt_u  ? pc_plus_imm : pc_plus4;
      OP_W'(OP_ADDI):   vd_n = vs1_plus_imm;
      OP_W'(OP_SLTI):   vd_n = XLEN'(lti_s);
      OP_W'(OP_SLTIU):  vd_n = XLEN'(lti_u);
      OP_W'(OP_XORI):   vd_n = iRS_Vs1 ^ iRS_Imm;
      OP_W'(OP_ORI):    vd_n = iRS_Vs1 | iRS_Imm;
      OP_W'(OP_ANDI):   vd_n = iRS_Vs1 & iRS_Imm;
      OP_W'(OP_SLLI):   vd_n = iRS_Vs1 << sh_imm;
      OP_W'(OP_SRLI):   vd_n = iRS_Vs1 >> sh_imm;
      OP_W'(OP_SRAI):   vd_n = $signed(iRS_Vs1) >>> sh_imm;
      OP_W'(OP_ADD):    vd_n = iRS_Vs1 + iRS_Vs2;
      OP_W'(OP_SUB):    vd_n = iRS_Vs1 - iRS_Vs2;
      OP_W'(OP_SLL):    vd_n = iRS_Vs1 << sh_reg;
      OP_W'(OP_SLT):    vd_n = XLEN'(lt_s);
      OP_W'(OP_SLTU):   vd_n = XLEN'(lt_u);
      OP_W'(OP_XOR):    vd_n = iRS_Vs1 ^ iRS_Vs2;
      OP_W'(OP_SRL):    vd_n = iRS_Vs1 >> sh_reg;
      OP_W'(OP_SRA):    vd_n = $signed(iRS_Vs1) >>> sh_reg;
      OP_W'(OP_OR):     vd_n = iRS_Vs1 | iRS_Vs2;
      OP_W'(OP_AND):    vd_n = iRS_Vs1 & iRS_Vs2;
      OP_W'(OP_MUL):    vd_n = mul_p[XLEN-1:0];
      OP_W'(OP_MULH),
      OP_W'(OP_MULHSU),
      OP_W'(OP_MULHU):  vd_n = mul_p[2*XLEN-1:XLEN];
      OP_W'(OP_DIV),
      OP_W'(OP_DIVU),
      OP_W'(OP_REM),
      OP_W'(OP_REMU):   vd_n = div_special_vd;
      default:          vd_n = '0;
    endcase
  end

  ex_div_unit #(
    .XLEN  (XLEN),
    .ROB_W (ROB_W)
  ) u_div (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .flush     (flush),
    .start     (div_start),
    .is_signed (div_signed),
    .is_rem    (div_rem),
    .dividend  (iRS_Vs1),
    .divisor   (iRS_Vs2),
    .tag_in    (iRS_Qd),
    .idle      (div_idle),
    .done      (div_done),
    .tag       (div_tag),
    .result    (div_result)
  );

  // CDB output register: divider completion or a single-cycle result, else zeros.
  always_ff @(posedge clk) begin
    if (rst) begin
      oCDB_En <= 1'b0;
      oCDB_Qd <= '0;
      oCDB_Vd <= '0;
      oCDB_Jt <= '0;
    end else if (en) begin
      if (flush) begin
        oCDB_En <= 1'b0;
        oCDB_Qd <= '0;
        oCDB_Vd <= '0;
        oCDB_Jt <= '0;
      end else if (div_done) begin
        oCDB_En <= 1'b1;
        oCDB_Qd <= div_tag;
        oCDB_Vd <= div_result;
        oCDB_Jt <= '0;
      end else if (accept && !div_start) begin
        oCDB_En <= 1'b1;
        oCDB_Qd <= iRS_Qd;
        oCDB_Vd <= vd_n;
        oCDB_Jt <= jt_n;
      end else begin
        oCDB_En <= 1'b0;
        oCDB_Qd <= '0;
        oCDB_Vd <= '0;
        oCDB_Jt <= '0;
      end
    end
  end

  // The RS must never issue into a busy unit.
  assert property (@(posedge clk) disable iff (rst)
                   !(en && iRS_En && !flush && !oRS_Ready));

endmodule

// File: tb/tb_ex_unit_m.sv
// Directed bench for ex_unit_m: ALU, branch, multiply, divide timing,
// special divide cases, flush, clock enable and mid-divide reset.

module tb_ex_unit_m;
  import ex_unit_m_pkg::*;

  logic        clk;
  logic        rst;
  logic        en;
  logic        flush;
  logic        iRS_En;
  logic        oRS_Ready;
  logic [5:0]  iRS_Op;
  logic [31:0] iRS_Pc;
  logic [31:0] iRS_Imm;
  logic [31:0] iRS_Vs1;
  logic [31:0] iRS_Vs2;
  logic [3:0]  iRS_Qd;
  logic        oCDB_En;
  logic [3:0]  oCDB_Qd;
  logic [31:0] oCDB_Vd;
  logic [31:0] oCDB_Jt;

  int compareCount  = 0;
  int mismatchCount = 0;

  ex_unit_m #(
    .XLEN  (32),
    .ROB_W (4),
    .OP_W  (6)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .flush     (flush),
    .iRS_En    (iRS_En),
    .oRS_Ready (oRS_Ready),
    .iRS_Op    (iRS_Op),
    .iRS_Pc    (iRS_Pc),
    .iRS_Imm   (iRS_Imm),
    .iRS_Vs1   (iRS_Vs1),
    .iRS_Vs2   (iRS_Vs2),
    .iRS_Qd    (iRS_Qd),
    .oCDB_En   (oCDB_En),
    .oCDB_Qd   (oCDB_Qd),
    .oCDB_Vd   (oCDB_Vd),
    .oCDB_Jt   (oCDB_Jt)
  );

  // Free-running clock, 10 time units per period
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check1(input string name, input logic [31:0] obs, input logic [31:0] exp);
    compareCount++;
    assert (obs === exp) else begin
      mismatchCount++;
      $error("[TB] FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [5:0] op, input logic [31:0] pc,
                               input logic [31:0] imm, input logic [31:0] vs1,
                               input logic [31:0] vs2, input logic [3:0] qd);
    iRS_En  = 1'b1;
    iRS_Op  = op;
    iRS_Pc  = pc;
    iRS_Imm = imm;
    iRS_Vs1 = vs1;
    iRS_Vs2 = vs2;
    iRS_Qd  = qd;
  endtask

  task automatic idleIssue();
    iRS_En = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input logic en_e, input logic [3:0] qd_e,
                             input logic [31:0] vd_e, input logic [31:0] jt_e);
    check1({tag, ".en"}, 32'(oCDB_En), 32'(en_e));
    check1({tag, ".qd"}, 32'(oCDB_Qd), 32'(qd_e));
    check1({tag, ".vd"}, oCDB_Vd, vd_e);
    check1({tag, ".jt"}, oCDB_Jt, jt_e);
  endtask

  // Issue one op and check its single-cycle broadcast
  task automatic runSingle(input string tag, input logic [5:0] op, input logic [31:0] pc,
                           input logic [31:0] imm, input logic [31:0] vs1,
                           input logic [31:0] vs2, input logic [3:0] qd,
                           input logic [31:0] vd_e, input logic [31:0] jt_e);
    applyStimulus(op, pc, imm, vs1, vs2, qd);
    tick();
    idleIssue();
    checkOutput(tag, 1'b1, qd, vd_e, jt_e);
  endtask

  // Issue an iterative divide, measure the busy window and check the result
  task automatic runDivide(input string tag, input logic [5:0] op, input logic [31:0] vs1,
                           input logic [31:0] vs2, input logic [3:0] qd,
                           input logic [31:0] vd_e);
    int lowCycles;
    applyStimulus(op, 32'h0, 32'h0, vs1, vs2, qd);
    tick();
    idleIssue();
    lowCycles = 0;
    while (!oRS_Ready && lowCycles < 40) begin
      lowCycles++;
      tick();
    end
    check1({tag, ".busy"}, 32'(lowCycles), 32'd33);
    checkOutput(tag, 1'b1, qd, vd_e, 32'h0);
    tick();
    check1({tag, ".after"}, 32'(oCDB_En), 32'd0);
  endtask

  initial begin
    int enHigh;
    rst = 1'b1; en = 1'b1; flush = 1'b0;
    iRS_En = 1'b0; iRS_Op = '0; iRS_Pc = '0; iRS_Imm = '0;
    iRS_Vs1 = '0; iRS_Vs2 = '0; iRS_Qd = '0;
    tick();
    tick();
    rst = 1'b0;
    checkOutput("reset", 1'b0, 4'd0, 32'h0, 32'h0);
    check1("reset.ready", 32'(oRS_Ready), 32'd1);

    // ALU result, then one idle cycle
    runSingle("addi", OP_ADDI, 32'h0, 32'hFFFF_FFFD, 32'd5, 32'h0, 4'd7, 32'd2, 32'h0);
    tick();
    checkOutput("idle", 1'b0, 4'd0, 32'h0, 32'h0);

    // Branches back-to-back
    runSingle("bge",  OP_BGE,  32'h100, 32'h20, 32'd9, 32'd9, 4'd1, 32'h0, 32'h120);
    runSingle("bgeu", OP_BGEU, 32'h100, 32'h20, 32'd1, 32'hFFFF_FFFF, 4'd2, 32'h0, 32'h104);
    runSingle("blt",  OP_BLT,  32'h200, 32'hFFFF_FFF8, 32'hFFFF_FFFF, 32'd1, 4'd3, 32'h0, 32'h1F8);
    runSingle("bne",  OP_BNE,  32'h200, 32'h40, 32'd4, 32'd4, 4'd4, 32'h0, 32'h204);
    runSingle("jalr", OP_JALR, 32'h40, 32'd4, 32'h1001, 32'h0, 4'd5, 32'h44, 32'h1004);
    runSingle("jal",  OP_JAL,  32'h40, 32'h80, 32'h0, 32'h0, 4'd6, 32'h44, 32'hC0);

    // Shifts use only the low five bits of the amount
    runSingle("srai", OP_SRAI, 32'h0, 32'h24, 32'h8000_0000, 32'h0, 4'd8, 32'hF800_0000, 32'h0);
    runSingle("srl",  OP_SRL,  32'h0, 32'h0, 32'h8000_0000, 32'h21, 4'd9, 32'h4000_0000, 32'h0);
    runSingle("sub",  OP_SUB,  32'h0, 32'h0, 32'd3, 32'd5, 4'd10, 32'hFFFF_FFFE, 32'h0);
    runSingle("sltu", OP_SLTU, 32'h0, 32'h0, 32'd1, 32'hFFFF_FFFF, 4'd11, 32'd1, 32'h0);
    runSingle("slt",  OP_SLT,  32'h0, 32'h0, 32'd1, 32'hFFFF_FFFF, 4'd12, 32'd0, 32'h0);

    // Multiply variants
    runSingle("mulh",   OP_MULH,   32'h0, 32'h0, 32'h8000_0000, 32'd2, 4'd1, 32'hFFFF_FFFF, 32'h0);
    runSingle("mulhu",  OP_MULHU,  32'h0, 32'h0, 32'h8000_0000, 32'd2, 4'd2, 32'd1, 32'h0);
    runSingle("mulhsu", OP_MULHSU, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd3, 32'hFFFF_FFFF, 32'h0);
    runSingle("mul",    OP_MUL,    32'h0, 32'h0, 32'd7, 32'd6, 4'd4, 32'd42, 32'h0);

    // Iterative divides
    runDivide("div",  OP_DIV,  32'hFFFF_FFF9, 32'd2, 4'd3, 32'hFFFF_FFFD);
    runDivide("rem",  OP_REM,  32'hFFFF_FFF9, 32'd2, 4'd4, 32'hFFFF_FFFF);
    runDivide("divu", OP_DIVU, 32'd100, 32'd7, 4'd5, 32'd14);

    // Special divides complete with ALU latency
    runSingle("divu0", OP_DIVU, 32'h0, 32'h0, 32'h1234, 32'h0, 4'd5, 32'hFFFF_FFFF, 32'h0);
    check1("divu0.ready", 32'(oRS_Ready), 32'd1);
    runSingle("remu0", OP_REMU, 32'h0, 32'h0, 32'h1234, 32'h0, 4'd6, 32'h1234, 32'h0);
    runSingle("divov", OP_DIV, 32'h0, 32'h0, 32'h8000_0000, 32'hFFFF_FFFF, 4'd7, 32'h8000_0000, 32'h0);
    runSingle("remov", OP_REM, 32'h0, 32'h0, 32'h8000_0000, 32'hFFFF_FFFF, 4'd8, 32'h0, 32'h0);

    // Flush during cycle 10 of a divide, with a dropped issue at the same edge
    applyStimulus(OP_DIV, 32'h0, 32'h0, 32'd100, 32'd7, 4'd6);
    tick();
    idleIssue();
    for (int i = 0; i < 9; i++) tick();
    check1("flush.busy", 32'(oRS_Ready), 32'd0);
    flush = 1'b1;
    applyStimulus(OP_ADD, 32'h0, 32'h0, 32'd1, 32'd1, 4'd9);
    tick();
    flush = 1'b0;
    idleIssue();
    checkOutput("flush", 1'b0, 4'd0, 32'h0, 32'h0);
    check1("flush.ready", 32'(oRS_Ready), 32'd1);
    runSingle("postflush", OP_ADD, 32'h0, 32'h0, 32'd10, 32'd20, 4'd8, 32'd30, 32'h0);
    enHigh = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (oCDB_En) enHigh++;
    end
    check1("flush.stale", 32'(enHigh), 32'd0);

    // Clock enable low holds the broadcast
    runSingle("en.issue", OP_ADD, 32'h0, 32'h0, 32'd1, 32'd2, 4'd10, 32'd3, 32'h0);
    en = 1'b0;
    tick();
    checkOutput("en.hold", 1'b1, 4'd10, 32'd3, 32'h0);
    en = 1'b1;
    tick();
    check1("en.resume", 32'(oCDB_En), 32'd0);

    // Reset in the middle of a divide
    applyStimulus(OP_DIVU, 32'h0, 32'h0, 32'd100, 32'd7, 4'd11);
    tick();
    idleIssue();
    for (int i = 0; i < 5; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("midrst", 1'b0, 4'd0, 32'h0, 32'h0);
    check1("midrst.ready", 32'(oRS_Ready), 32'd1);
    enHigh = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (oCDB_En) enHigh++;
    end
    check1("midrst.stale", 32'(enHigh), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
